useq_run_ctrl: RTL

//  Run/halt/step controller for the microsequencer. Owns the microsequencer clock enable and

---
 rtl/useq_run_ctrl_if.sv | 27 ++
 rtl/useq_run_ctrl.sv | 108 ++++++++++
 2 files changed

// File: rtl/useq_run_ctrl_if.sv
// useq_run_ctrl_if: console and microsequencer signals of useq_run_ctrl; USEQ_UBREAK_EN adds brkEN/brkADDR
interface useq_run_ctrl_if;
    logic        consRUN, consEXEC, consHALT, consSTEP, haltLOOP;
    logic [11:0] useqADDR;
    logic        clken, useqRST, cpuCONT, cpuEXEC, cpuRUN, cpuHALT, stepACK;
`ifdef USEQ_UBREAK_EN
    logic        brkEN;
    logic [11:0] brkADDR;
    modport master (
        output consRUN, consEXEC, consHALT, consSTEP, haltLOOP, useqADDR, brkEN, brkADDR,
        input  clken, useqRST, cpuCONT, cpuEXEC, cpuRUN, cpuHALT, stepACK
    );
    modport slave (
        input  consRUN, consEXEC, consHALT, consSTEP, haltLOOP, useqADDR, brkEN, brkADDR,
        output clken, useqRST, cpuCONT, cpuEXEC, cpuRUN, cpuHALT, stepACK
    );
`else
    modport master (
        output consRUN, consEXEC, consHALT, consSTEP, haltLOOP, useqADDR,
        input  clken, useqRST, cpuCONT, cpuEXEC, cpuRUN, cpuHALT, stepACK
    );
    modport slave (
        input  consRUN, consEXEC, consHALT, consSTEP, haltLOOP, useqADDR,
        output clken, useqRST, cpuCONT, cpuEXEC, cpuRUN, cpuHALT, stepACK
    );
`endif
endinterface

// File: rtl/useq_run_ctrl.sv
// useq_run_ctrl: run/halt/step controller for the microsequencer; USEQ_UBREAK_EN adds a microcode address breakpoint
module useq_run_ctrl #(
    parameter int RST_TICKS = 4,
    parameter int CLKDIV    = 1
) (
    input logic            clk,
    input logic            rst_n,
    useq_run_ctrl_if.slave bus
);
    typedef enum logic [2:0] {RESET, HALT, CONT, RUN, FREEZE} state_t;
    localparam logic [3:0]  DIV_LAST = 4'(CLKDIV - 1);
    localparam logic [15:0] RST_LAST = 16'(RST_TICKS - 1);
    state_t      state_q, state_d;
    logic [3:0]  div_q, div_d;
    logic [15:0] rst_cnt_q, rst_cnt_d;
    logic        step_pend_q, step_pend_d, exec_q, exec_d, hl_q, hl_d;
    logic        useq_rst_q, useq_rst_d, cpu_halt_q, cpu_halt_d, cpu_run_q, cpu_run_d;
    logic        cpu_cont_q, cpu_cont_d, cpu_exec_q, cpu_exec_d, step_ack_q, step_ack_d;
    logic        tick, brk_hit;
    assign tick      = div_q == DIV_LAST;
    assign bus.clken = tick & ((state_q != FREEZE) | step_pend_q);
`ifdef USEQ_UBREAK_EN
    assign brk_hit = bus.clken & bus.brkEN & (bus.useqADDR == bus.brkADDR);
`else
    assign brk_hit = 1'b0;
`endif
    always_comb begin
        div_d       = tick ? 4'd0 : div_q + 4'd1;
        hl_d        = bus.haltLOOP;
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        step_pend_d = step_pend_q;
        exec_d      = exec_q;
        step_ack_d  = 1'b0;
        case (state_q)
            RESET: begin
                rst_cnt_d = tick ? rst_cnt_q + 16'd1 : rst_cnt_q;
                state_d   = (tick && rst_cnt_q == RST_LAST) ? HALT : RESET;
            end
            HALT: begin
                if (bus.consSTEP) begin
                    state_d     = FREEZE;
                    step_pend_d = 1'b1;
                end else if (bus.consRUN) begin
                    state_d = CONT;
                    exec_d  = bus.consEXEC;
                end
            end
            CONT: state_d = (bus.consHALT || brk_hit) ? FREEZE : !bus.haltLOOP ? RUN : CONT;
            RUN:  state_d = (bus.consHALT || brk_hit) ? FREEZE : (bus.haltLOOP && !hl_q) ? HALT : RUN;
            FREEZE: begin
                // a step request arriving while one is pending is dropped
                if (tick && step_pend_q) begin
                    step_pend_d = 1'b0;
                    step_ack_d  = 1'b1;
                end else if (bus.consSTEP) begin
                    step_pend_d = 1'b1;
                end
                if (bus.consRUN) begin
                    state_d     = bus.haltLOOP ? CONT : RUN;
                    exec_d      = bus.consEXEC;
                    step_pend_d = 1'b0;
                end
            end
            default: state_d = RESET;
        endcase
        useq_rst_d = state_d == RESET;
        cpu_halt_d = state_d == HALT;
        cpu_run_d  = state_d == RUN || state_d == CONT;
        cpu_cont_d = state_d == CONT;
        cpu_exec_d = state_d == CONT && exec_d;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RESET;
            div_q       <= '0;
            rst_cnt_q   <= '0;
            step_pend_q <= 1'b0;
            exec_q      <= 1'b0;
            hl_q        <= 1'b0;
            useq_rst_q  <= 1'b1;
            cpu_halt_q  <= 1'b0;
            cpu_run_q   <= 1'b0;
            cpu_cont_q  <= 1'b0;
            cpu_exec_q  <= 1'b0;
            step_ack_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            rst_cnt_q   <= rst_cnt_d;
            step_pend_q <= step_pend_d;
            exec_q      <= exec_d;
            hl_q        <= hl_d;
            useq_rst_q  <= useq_rst_d;
            cpu_halt_q  <= cpu_halt_d;
            cpu_run_q   <= cpu_run_d;
            cpu_cont_q  <= cpu_cont_d;
            cpu_exec_q  <= cpu_exec_d;
            step_ack_q  <= step_ack_d;
        end
    end
    assign bus.useqRST = useq_rst_q;
    assign bus.cpuHALT = cpu_halt_q;
    assign bus.cpuRUN  = cpu_run_q;
    assign bus.cpuCONT = cpu_cont_q;
    assign bus.cpuEXEC = cpu_exec_q;
    assign bus.stepACK = step_ack_q;
endmodule
